// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the 640x480@60 VGA sync generator.
// Holds the default geometry, derived totals and sync windows, and a window-decode helper.
package vga_timing_pkg;

    localparam int CNT_W = 11;
    localparam int DIV_W = 4;

    localparam int DEF_CLK_DIV   = 2;
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
    localparam int DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

    // Half-open window test [lo, hi) on a counter value.
    function automatic logic in_window(
        input logic [CNT_W-1:0] val,
        input logic [CNT_W-1:0] lo,
        input logic [CNT_W-1:0] hi
    );
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/pix_tick_div.sv
// Pixel-rate divider: asserts tick for one clk out of every CLK_DIV clks.
// The tick lands in the cycle where the divider count reaches CLK_DIV-1.
module pix_tick_div
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
)(
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_r;

    // Divider count, wrapping at CLK_DIV-1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_r <= {DIV_W{1'b0}};
        end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= {DIV_W{1'b0}};
        end else begin
            div_cnt_r <= div_cnt_r + 4'd1;
        end
    end

    assign tick = (div_cnt_r == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing master: pixel/line counters, sync and visible decode, RGB blanking.
// Every output is loaded together on a pixel tick, one tick behind the internal counters.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int   CLK_DIV   = DEF_CLK_DIV,
    parameter int   H_VISIBLE = DEF_H_VISIBLE,
    parameter int   H_FRONT   = DEF_H_FRONT,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BACK    = DEF_H_BACK,
    parameter int   V_VISIBLE = DEF_V_VISIBLE,
    parameter int   V_FRONT   = DEF_V_FRONT,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BACK    = DEF_V_BACK,
    parameter logic SYNC_POL  = 1'b0
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Rin,
    input  logic             Gin,
    input  logic             Bin,
    output logic             Rout,
    output logic             Gout,
    output logic             Bout,
    output logic             h_sinc,
    output logic             v_sinc,
    output logic [CNT_W-1:0] countH,
    output logic [CNT_W-1:0] countV,
    output logic             visible,
    output logic             pix_tick,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic             tick_s;
    logic [CNT_W-1:0] h_cnt_r;
    logic [CNT_W-1:0] v_cnt_r;
    logic [CNT_W-1:0] h_next_s;
    logic [CNT_W-1:0] v_next_s;
    logic             vis_s;
    logic             hs_act_s;
    logic             vs_act_s;

    pix_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick_s)
    );

    // Next counter position; a line wrap on the last line also wraps the frame
    always_comb begin
        h_next_s = h_cnt_r + 11'd1;
        v_next_s = v_cnt_r;
        if (h_cnt_r == H_LAST) begin
            h_next_s = CNT_ZERO;
            if (v_cnt_r == V_LAST) begin
                v_next_s = CNT_ZERO;
            end else begin
                v_next_s = v_cnt_r + 11'd1;
            end
        end else begin
            v_next_s = v_cnt_r;
        end
    end

    // Decode of the current internal position, loaded into the outputs on the tick
    always_comb begin
        vis_s    = (h_cnt_r < H_VIS) && (v_cnt_r < V_VIS);
        hs_act_s = in_window(h_cnt_r, HS_START, HS_END);
        vs_act_s = in_window(v_cnt_r, VS_START, VS_END);
    end

    // Internal pixel/line counters, advancing only on a tick
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt_r <= CNT_ZERO;
            v_cnt_r <= CNT_ZERO;
        end else if (tick_s) begin
            h_cnt_r <= h_next_s;
            v_cnt_r <= v_next_s;
        end else begin
            h_cnt_r <= h_cnt_r;
            v_cnt_r <= v_cnt_r;
        end
    end

    // Output stage; strobes last one clk, everything else holds between ticks
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            countH      <= CNT_ZERO;
            countV      <= CNT_ZERO;
            h_sinc      <= ~SYNC_POL;
            v_sinc      <= ~SYNC_POL;
            visible     <= 1'b0;
            Rout        <= 1'b0;
            Gout        <= 1'b0;
            Bout        <= 1'b0;
            pix_tick    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (tick_s) begin
            countH      <= h_cnt_r;
            countV      <= v_cnt_r;
            h_sinc      <= hs_act_s ? SYNC_POL : ~SYNC_POL;
            v_sinc      <= vs_act_s ? SYNC_POL : ~SYNC_POL;
            visible     <= vis_s;
            Rout        <= vis_s & Rin;
            Gout        <= vis_s & Gin;
            Bout        <= vis_s & Bin;
            pix_tick    <= 1'b1;
            line_start  <= (h_cnt_r == CNT_ZERO);
            frame_start <= (h_cnt_r == CNT_ZERO) && (v_cnt_r == CNT_ZERO);
        end else begin
            pix_tick    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default geometry at CLK_DIV=2 and 1, plus a shrunken geometry
// so that frame wrap, vertical sync and mid-frame reset can be reached in a short run.
module tb_vga_sync_gen;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        vis;
        logic        pt;
        logic        ls;
        logic        fs;
        logic [2:0]  rgb;
    } obs_t;

    localparam int S_DIV = 3;
    localparam int S_HV = 8, S_HF = 2, S_HS = 3, S_HB = 2;
    localparam int S_VV = 5, S_VF = 1, S_VS = 2, S_VB = 2;

    localparam int G_DIV [3] = '{2, 1, S_DIV};
    localparam int G_HV  [3] = '{640, 640, S_HV};
    localparam int G_HF  [3] = '{16, 16, S_HF};
    localparam int G_HS  [3] = '{96, 96, S_HS};
    localparam int G_HB  [3] = '{48, 48, S_HB};
    localparam int G_VV  [3] = '{480, 480, S_VV};
    localparam int G_VF  [3] = '{10, 10, S_VF};
    localparam int G_VS  [3] = '{2, 2, S_VS};
    localparam int G_VB  [3] = '{33, 33, S_VB};

    logic        clk;
    logic        rst_n;
    logic        Rin, Gin, Bin;
    logic [10:0] cH [3];
    logic [10:0] cV [3];
    logic        rO [3];
    logic        gO [3];
    logic        bO [3];
    logic        hs [3];
    logic        vs [3];
    logic        vis [3];
    logic        pt [3];
    logic        ls [3];
    logic        fs [3];
    obs_t        obs [3];

    int          checks = 0;
    int          errors = 0;
    int          clks [3];
    logic [2:0]  rgbRec [3];
    obs_t        rstObs;

    vga_sync_gen #(.CLK_DIV(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .Rin(Rin), .Gin(Gin), .Bin(Bin),
        .Rout(rO[0]), .Gout(gO[0]), .Bout(bO[0]), .h_sinc(hs[0]), .v_sinc(vs[0]),
        .countH(cH[0]), .countV(cV[0]), .visible(vis[0]), .pix_tick(pt[0]),
        .line_start(ls[0]), .frame_start(fs[0])
    );

    vga_sync_gen #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .Rin(Rin), .Gin(Gin), .Bin(Bin),
        .Rout(rO[1]), .Gout(gO[1]), .Bout(bO[1]), .h_sinc(hs[1]), .v_sinc(vs[1]),
        .countH(cH[1]), .countV(cV[1]), .visible(vis[1]), .pix_tick(pt[1]),
        .line_start(ls[1]), .frame_start(fs[1])
    );

    vga_sync_gen #(
        .CLK_DIV(S_DIV), .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB), .SYNC_POL(1'b0)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .Rin(Rin), .Gin(Gin), .Bin(Bin),
        .Rout(rO[2]), .Gout(gO[2]), .Bout(bO[2]), .h_sinc(hs[2]), .v_sinc(vs[2]),
        .countH(cH[2]), .countV(cV[2]), .visible(vis[2]), .pix_tick(pt[2]),
        .line_start(ls[2]), .frame_start(fs[2])
    );

    for (genvar k = 0; k < 3; k++) begin : g_obs
        assign obs[k] = {cH[k], cV[k], hs[k], vs[k], vis[k], pt[k], ls[k], fs[k], rO[k], gO[k], bO[k]};
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference bookkeeping: clk edges since reset release, and the colour sampled on each tick edge
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                clks[k]   <= 0;
                rgbRec[k] <= 3'b000;
            end else begin
                clks[k] <= clks[k] + 1;
                if ((clks[k] + 1) % G_DIV[k] == 0) rgbRec[k] <= {Rin, Gin, Bin};
            end
        end
    end

    // Expected outputs from elapsed time: the n-th tick shows pixel n of the raster scan
    function automatic obs_t model(input int k);
        obs_t e;
        int n, h, v, ht, vt, hss, vss;
        e    = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        if (clks[k] >= G_DIV[k]) begin
            ht    = G_HV[k] + G_HF[k] + G_HS[k] + G_HB[k];
            vt    = G_VV[k] + G_VF[k] + G_VS[k] + G_VB[k];
            n     = clks[k] / G_DIV[k] - 1;
            h     = n % ht;
            v     = (n / ht) % vt;
            hss   = G_HV[k] + G_HF[k];
            vss   = G_VV[k] + G_VF[k];
            e.h   = 11'(h);
            e.v   = 11'(v);
            e.vis = (h < G_HV[k]) && (v < G_VV[k]);
            e.hs  = !((h >= hss) && (h < hss + G_HS[k]));
            e.vs  = !((v >= vss) && (v < vss + G_VS[k]));
            e.pt  = (clks[k] % G_DIV[k] == 0);
            e.ls  = e.pt && (h == 0);
            e.fs  = e.ls && (v == 0);
            e.rgb = e.vis ? rgbRec[k] : 3'b000;
        end
        return e;
    endfunction

    task automatic test_reset();
        obs_t first;
        rst_n = 1'b0;
        {Rin, Gin, Bin} = 3'b000;
        repeat (5) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== rstObs) begin
                errors++;
                $display("FAIL reset_state dut%0d: got %h expected %h", k, obs[k], rstObs);
            end
        end
        first     = rstObs;
        first.vis = 1'b1;
        first.pt  = 1'b1;
        first.ls  = 1'b1;
        first.fs  = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs[0] !== rstObs) begin
            errors++;
            $display("FAIL div2_one_clk_after_release: got %h expected %h", obs[0], rstObs);
        end
        checks++;
        if (obs[1] !== first) begin
            errors++;
            $display("FAIL div1_first_tick: got %h expected %h", obs[1], first);
        end
        @(negedge clk);
        checks++;
        if (obs[0] !== first) begin
            errors++;
            $display("FAIL div2_first_tick: got %h expected %h", obs[0], first);
        end
    endtask

    task automatic test_free_run(input int ncyc);
        obs_t expd;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                expd = model(k);
                checks++;
                if (obs[k] !== expd) begin
                    errors++;
                    $display("FAIL model dut%0d t=%0t: got h=%0d v=%0d flags=%b rgb=%b expected h=%0d v=%0d flags=%b rgb=%b",
                             k, $time, obs[k].h, obs[k].v,
                             {obs[k].hs, obs[k].vs, obs[k].vis, obs[k].pt, obs[k].ls, obs[k].fs}, obs[k].rgb,
                             expd.h, expd.v, {expd.hs, expd.vs, expd.vis, expd.pt, expd.ls, expd.fs}, expd.rgb);
                end
            end
            {Rin, Gin, Bin} = 3'($urandom);
        end
    endtask

    task automatic test_hsync_line(input int k, input int expPeriod);
        int first = -1, period = -1, ticks = 0, low = 0, firstLow = -1;
        for (int cyc = 0; cyc < 6000 && period < 0; cyc++) begin
            @(negedge clk);
            if (obs[k].ls) begin
                if (first < 0) first = cyc;
                else           period = cyc - first;
            end
            if (first >= 0 && period < 0 && obs[k].pt) begin
                ticks++;
                if (!obs[k].hs) begin
                    low++;
                    if (firstLow < 0) firstLow = int'(obs[k].h);
                end
            end
        end
        checks++;
        if (period != expPeriod) begin
            errors++;
            $display("FAIL line_period dut%0d: got %0d clks expected %0d", k, period, expPeriod);
        end
        checks++;
        if (ticks != 800) begin
            errors++;
            $display("FAIL ticks_per_line dut%0d: got %0d expected 800", k, ticks);
        end
        checks++;
        if (low != 96) begin
            errors++;
            $display("FAIL hsync_width dut%0d: got %0d expected 96", k, low);
        end
        checks++;
        if (firstLow != 656) begin
            errors++;
            $display("FAIL hsync_start dut%0d: got %0d expected 656", k, firstLow);
        end
    endtask

    task automatic test_clkdiv1();
        int ptCnt = 0;
        test_hsync_line(1, 800);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (pt[1]) ptCnt++;
        end
        checks++;
        if (ptCnt != 50) begin
            errors++;
            $display("FAIL div1_tick_every_clk: got %0d expected 50", ptCnt);
        end
    endtask

    task automatic test_rgb_const();
        bit seen639 = 0, seen640 = 0, seenV = 0;
        logic [2:0] expRgb;
        {Rin, Gin, Bin} = 3'b111;
        for (int c = 0; c < 1700; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k += 2) begin
                if (obs[k].pt) begin
                    expRgb = ((int'(obs[k].h) < G_HV[k]) && (int'(obs[k].v) < G_VV[k])) ? 3'b111 : 3'b000;
                    checks++;
                    if (obs[k].rgb !== expRgb) begin
                        errors++;
                        $display("FAIL rgb_blank dut%0d h=%0d v=%0d: got %b expected %b",
                                 k, obs[k].h, obs[k].v, obs[k].rgb, expRgb);
                    end
                    if (k == 0 && obs[k].h == 11'd639) seen639 = 1;
                    if (k == 0 && obs[k].h == 11'd640) seen640 = 1;
                    if (k == 2 && int'(obs[k].v) == S_VV) seenV = 1;
                end
            end
        end
        checks++;
        if (!(seen639 && seen640 && seenV)) begin
            errors++;
            $display("FAIL rgb_boundaries_reached: got %b%b%b expected 111", seen639, seen640, seenV);
        end
    endtask

    task automatic test_wrap();
        localparam int HT = S_HV + S_HF + S_HS + S_HB;
        localparam int VT = S_VV + S_VF + S_VS + S_VB;
        bit found = 0, next = 0, done = 0;
        int low = 0, firstLowV = -1;
        for (int c = 0; c < 1000 && !found; c++) begin
            @(negedge clk);
            if (obs[2].pt && int'(obs[2].h) == HT - 1 && int'(obs[2].v) == VT - 1) found = 1;
        end
        for (int c = 0; c < S_DIV + 1 && found && !next; c++) begin
            @(negedge clk);
            if (obs[2].pt) next = 1;
        end
        checks++;
        if (!(next && obs[2].h == 11'd0 && obs[2].v == 11'd0 && obs[2].fs && obs[2].ls)) begin
            errors++;
            $display("FAIL frame_wrap: got found=%b h=%0d v=%0d fs=%b ls=%b expected h=0 v=0 fs=1 ls=1",
                     next, obs[2].h, obs[2].v, obs[2].fs, obs[2].ls);
        end
        for (int c = 0; c < 600 && !done; c++) begin
            if (obs[2].pt && !obs[2].vs) begin
                low++;
                if (firstLowV < 0) firstLowV = int'(obs[2].v);
            end
            @(negedge clk);
            if (obs[2].fs) done = 1;
        end
        checks++;
        if (!done || low != S_VS * HT || firstLowV != S_VV + S_VF) begin
            errors++;
            $display("FAIL vsync_window: got low_ticks=%0d first_line=%0d expected %0d and %0d",
                     low, firstLowV, S_VS * HT, S_VV + S_VF);
        end
    endtask

    task automatic test_mid_reset();
        obs_t first;
        bit found = 0;
        {Rin, Gin, Bin} = 3'b000;
        for (int c = 0; c < 1000 && !found; c++) begin
            @(negedge clk);
            if (obs[2].pt && obs[2].h == 11'd5 && obs[2].v == 11'd4) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_reset_position: got not found expected h=5 v=4");
        end
        repeat (S_DIV - 1) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (obs[2] !== rstObs) begin
            errors++;
            $display("FAIL mid_reset_state: got %h expected %h", obs[2], rstObs);
        end
        rst_n = 1'b1;
        repeat (S_DIV) @(negedge clk);
        first     = rstObs;
        first.vis = 1'b1;
        first.pt  = 1'b1;
        first.ls  = 1'b1;
        first.fs  = 1'b1;
        checks++;
        if (obs[2] !== first) begin
            errors++;
            $display("FAIL mid_reset_restart: got %h expected %h", obs[2], first);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        {Rin, Gin, Bin} = 3'b000;
        rstObs    = '0;
        rstObs.hs = 1'b1;
        rstObs.vs = 1'b1;
        test_reset();
        test_free_run(2000);
        test_hsync_line(0, 1600);
        test_clkdiv1();
        test_rgb_const();
        test_wrap();
        test_mid_reset();
        test_free_run(1500);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
